// File: rtl/id_ex_issue_if.sv
// rtl/id_ex_issue_if.sv - decode-side and ALU-side handshake bundle for the ID/EX issue stage
interface id_ex_issue_if #(
  parameter int ALU_DATA_WIDTH    = 32,
  parameter int ALU_CONTROL_WIDTH = 4,
  parameter int INST_ADDR_WIDTH   = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ALU_DATA_WIDTH-1:0]    in_rs1_data;
  logic [ALU_DATA_WIDTH-1:0]    in_rs2_data;
  logic [ALU_DATA_WIDTH-1:0]    in_imm;
  logic [4:0]                   in_rs1_addr;
  logic [4:0]                   in_rs2_addr;
  logic [4:0]                   in_rd_addr;
  logic                         in_use_imm;
  logic [ALU_CONTROL_WIDTH-1:0] in_alu_control;
  logic [INST_ADDR_WIDTH-1:0]   in_pc;

  logic                         out_valid;
  logic                         out_ready;
  logic [ALU_DATA_WIDTH-1:0]    input_data_1;
  logic [ALU_DATA_WIDTH-1:0]    input_data_2;
  logic [ALU_CONTROL_WIDTH-1:0] ALU_control;
  logic [INST_ADDR_WIDTH-1:0]   pc;
  logic [4:0]                   out_rd_addr;

  // Driving side: decode produces instructions and the ALU grants out_ready.
  modport master (
    output in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_use_imm, in_alu_control, in_pc, out_ready,
    input  in_ready, out_valid, input_data_1, input_data_2, ALU_control, pc, out_rd_addr
  );

  modport slave (
    input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
           in_rd_addr, in_use_imm, in_alu_control, in_pc, out_ready,
    output in_ready, out_valid, input_data_1, input_data_2, ALU_control, pc, out_rd_addr
  );
endinterface

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX issue register with skid entry, operand forwarding and writeback snooping
module id_ex_issue #(
  parameter int ALU_DATA_WIDTH    = 32,
  parameter int ALU_CONTROL_WIDTH = 4,
  parameter int INST_ADDR_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  id_ex_issue_if.slave              bus,
  input  logic                      exm_wr_en,
  input  logic [4:0]                exm_rd,
  input  logic [ALU_DATA_WIDTH-1:0] exm_data,
  input  logic                      mwb_wr_en,
  input  logic [4:0]                mwb_rd,
  input  logic [ALU_DATA_WIDTH-1:0] mwb_data,
  input  logic                      flush
);

  typedef struct packed {
    logic                         valid;
    logic [ALU_DATA_WIDTH-1:0]    rs1_val;
    logic [ALU_DATA_WIDTH-1:0]    rs2_val;
    logic [ALU_DATA_WIDTH-1:0]    imm;
    logic                         use_imm;
    logic [4:0]                   rs1_addr;
    logic [4:0]                   rs2_addr;
    logic [4:0]                   rd_addr;
    logic [ALU_CONTROL_WIDTH-1:0] alu_control;
    logic [INST_ADDR_WIDTH-1:0]   pc;
  } entry_t;

  entry_t out_q, skid_q;
  entry_t out_n, skid_n;
  entry_t out_s, skid_s;
  entry_t cap;

  logic accept;
  logic consume;

  // A held operand goes stale if the register it came from is written back while we wait.
  function automatic entry_t snoop(input entry_t e, input logic wr_en,
                                   input logic [4:0] rd, input logic [ALU_DATA_WIDTH-1:0] data);
    entry_t r;
    r = e;
    if (e.valid && wr_en && (rd != 5'd0)) begin
      if (rd == e.rs1_addr) r.rs1_val = data;
      if (rd == e.rs2_addr) r.rs2_val = data;
    end
    return r;
  endfunction

  function automatic logic [ALU_DATA_WIDTH-1:0] select_src(
    input logic [4:0] addr, input logic [ALU_DATA_WIDTH-1:0] rf_val,
    input logic ex_en, input logic [4:0] ex_rd, input logic [ALU_DATA_WIDTH-1:0] ex_val,
    input logic wb_en, input logic [4:0] wb_rd, input logic [ALU_DATA_WIDTH-1:0] wb_val);
    logic [ALU_DATA_WIDTH-1:0] v;
    v = rf_val;
    if (addr != 5'd0) begin
      if (ex_en && (ex_rd == addr))      v = ex_val;
      else if (wb_en && (wb_rd == addr)) v = wb_val;
    end
    return v;
  endfunction

  assign bus.in_ready = ~skid_q.valid;
  assign accept       = bus.in_valid & ~skid_q.valid;
  assign consume      = out_q.valid & bus.out_ready;

  always_comb begin
    cap             = '0;
    cap.valid       = 1'b1;
    cap.rs1_val     = select_src(bus.in_rs1_addr, bus.in_rs1_data, exm_wr_en, exm_rd, exm_data,
                                 mwb_wr_en, mwb_rd, mwb_data);
    cap.rs2_val     = select_src(bus.in_rs2_addr, bus.in_rs2_data, exm_wr_en, exm_rd, exm_data,
                                 mwb_wr_en, mwb_rd, mwb_data);
    cap.imm         = bus.in_imm;
    cap.use_imm     = bus.in_use_imm;
    cap.rs1_addr    = bus.in_rs1_addr;
    cap.rs2_addr    = bus.in_rs2_addr;
    cap.rd_addr     = bus.in_rd_addr;
    cap.alu_control = bus.in_alu_control;
    cap.pc          = bus.in_pc;
  end

  always_comb begin
    out_s  = snoop(out_q,  mwb_wr_en, mwb_rd, mwb_data);
    skid_s = snoop(skid_q, mwb_wr_en, mwb_rd, mwb_data);
    out_n  = out_s;
    skid_n = skid_s;
    if (flush) begin
      out_n.valid  = 1'b0;
      skid_n.valid = 1'b0;
    end else if (consume || !out_q.valid) begin
      // OUT frees up: the older skid entry goes first to keep acceptance order.
      if (skid_q.valid) begin
        out_n        = skid_s;
        skid_n.valid = 1'b0;
      end else if (accept) begin
        out_n = cap;
      end else begin
        out_n.valid = 1'b0;
      end
    end else if (accept) begin
      skid_n = cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_n;
      skid_q <= skid_n;
    end
  end

  assign bus.out_valid    = out_q.valid;
  assign bus.input_data_1 = out_q.rs1_val;
  assign bus.input_data_2 = out_q.use_imm ? out_q.imm : out_q.rs2_val;
  assign bus.ALU_control  = out_q.alu_control;
  assign bus.pc           = out_q.pc;
  assign bus.out_rd_addr  = out_q.rd_addr;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb/tb_id_ex_issue.sv - directed self-checking bench for id_ex_issue
module tb_id_ex_issue;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          exm_wr_en, mwb_wr_en, flush;
  logic [4:0]    exm_rd, mwb_rd;
  logic [DW-1:0] exm_data, mwb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_issue_if #(.ALU_DATA_WIDTH(DW), .ALU_CONTROL_WIDTH(CW), .INST_ADDR_WIDTH(AW)) bus ();

  id_ex_issue #(.ALU_DATA_WIDTH(DW), .ALU_CONTROL_WIDTH(CW), .INST_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .exm_data  (exm_data),
    .mwb_wr_en (mwb_wr_en),
    .mwb_rd    (mwb_rd),
    .mwb_data  (mwb_data),
    .flush     (flush)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                      input logic ui, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] rd, input logic [3:0] ctl, input logic [31:0] pcv);
    bus.in_valid       = 1'b1;
    bus.in_rs1_data    = r1;
    bus.in_rs2_data    = r2;
    bus.in_imm         = imm;
    bus.in_use_imm     = ui;
    bus.in_rs1_addr    = a1;
    bus.in_rs2_addr    = a2;
    bus.in_rd_addr     = rd;
    bus.in_alu_control = ctl;
    bus.in_pc          = pcv;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    exm_wr_en = 1'b0; exm_rd = '0; exm_data = '0;
    mwb_wr_en = 1'b0; mwb_rd = '0; mwb_data = '0;
    flush = 1'b0;
    send(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0, 32'h0);
    idle();

    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_d1", bus.input_data_1, 0);
    check("rst_d2", bus.input_data_2, 0);
    check("rst_ctl", bus.ALU_control, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_rd", bus.out_rd_addr, 0);
    send(32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'h1, 32'h10);
    tick();
    check("rst_no_capture", bus.out_valid, 0);
    idle();
    #2 rst_n = 1'b1;

    // first acceptance on the first edge after reset release
    send(32'd5, 32'd7, 32'h0, 1'b0, 5'd1, 5'd2, 5'd4, 4'h3, 32'h100);
    bus.out_ready = 1'b1;
    tick();
    idle();
    check("basic_valid", bus.out_valid, 1);
    check("basic_d1", bus.input_data_1, 5);
    check("basic_d2", bus.input_data_2, 7);
    check("basic_ctl", bus.ALU_control, 3);
    check("basic_pc", bus.pc, 32'h100);
    check("basic_rd", bus.out_rd_addr, 4);
    tick();
    check("basic_drain", bus.out_valid, 0);

    // back-pressure: A in OUT, B in SKID
    bus.out_ready = 1'b0;
    send(32'hA1, 32'hA2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd5, 4'h1, 32'h200);
    tick();
    send(32'hB1, 32'hB2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd6, 4'h2, 32'h204);
    tick();
    idle();
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_valid", bus.out_valid, 1);
    check("bp_a_d1", bus.input_data_1, 32'hA1);
    check("bp_a_pc", bus.pc, 32'h200);
    tick();
    check("bp_hold_d1", bus.input_data_1, 32'hA1);
    check("bp_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_valid", bus.out_valid, 1);
    check("bp_b_d1", bus.input_data_1, 32'hB1);
    check("bp_b_pc", bus.pc, 32'h204);
    check("bp_b_rd", bus.out_rd_addr, 6);
    check("bp_in_ready_free", bus.in_ready, 1);
    tick();
    check("bp_drain", bus.out_valid, 0);

    // capture-time forwarding priority
    exm_wr_en = 1'b1; exm_rd = 5'd3; exm_data = 32'h11;
    mwb_wr_en = 1'b1; mwb_rd = 5'd3; mwb_data = 32'h22;
    send(32'h99, 32'h98, 32'h0, 1'b0, 5'd3, 5'd7, 5'd1, 4'h0, 32'h300);
    tick();
    check("fwd_exm_d1", bus.input_data_1, 32'h11);
    check("fwd_none_d2", bus.input_data_2, 32'h98);
    exm_rd = 5'd4;
    send(32'h99, 32'h98, 32'h0, 1'b0, 5'd3, 5'd4, 5'd1, 4'h0, 32'h304);
    tick();
    check("fwd_mwb_d1", bus.input_data_1, 32'h22);
    check("fwd_exm_d2", bus.input_data_2, 32'h11);
    exm_rd = 5'd0; mwb_rd = 5'd0;
    send(32'h99, 32'h98, 32'h0, 1'b0, 5'd0, 5'd0, 5'd1, 4'h0, 32'h308);
    tick();
    check("fwd_r0_d1", bus.input_data_1, 32'h99);
    check("fwd_r0_d2", bus.input_data_2, 32'h98);
    idle();
    exm_wr_en = 1'b0; mwb_wr_en = 1'b0;
    tick();
    check("fwd_drain", bus.out_valid, 0);

    // writeback snoop on a held OUT entry
    bus.out_ready = 1'b0;
    send(32'h31, 32'h55, 32'h40, 1'b0, 5'd0, 5'd9, 5'd2, 4'h5, 32'h400);
    tick();
    idle();
    check("snp_pre_d2", bus.input_data_2, 32'h55);
    mwb_wr_en = 1'b1; mwb_rd = 5'd9; mwb_data = 32'hAB;
    tick();
    mwb_wr_en = 1'b0;
    check("snp_d2", bus.input_data_2, 32'hAB);
    mwb_wr_en = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hEE;
    tick();
    mwb_wr_en = 1'b0;
    check("snp_r0_d1", bus.input_data_1, 32'h31);
    bus.out_ready = 1'b1;
    tick();
    check("snp_drain", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    send(32'h31, 32'h55, 32'h40, 1'b1, 5'd0, 5'd9, 5'd2, 4'h5, 32'h404);
    tick();
    idle();
    check("imm_d2", bus.input_data_2, 32'h40);
    mwb_wr_en = 1'b1; mwb_rd = 5'd9; mwb_data = 32'hAB;
    tick();
    mwb_wr_en = 1'b0;
    check("imm_snp_d2", bus.input_data_2, 32'h40);
    bus.out_ready = 1'b1;
    tick();

    // snoop reaches the SKID entry too
    bus.out_ready = 1'b0;
    send(32'h1, 32'h0, 32'h0, 1'b0, 5'd10, 5'd0, 5'd1, 4'h0, 32'h500);
    tick();
    send(32'h2, 32'h0, 32'h0, 1'b0, 5'd11, 5'd0, 5'd1, 4'h0, 32'h504);
    tick();
    idle();
    mwb_wr_en = 1'b1; mwb_rd = 5'd11; mwb_data = 32'h77;
    tick();
    mwb_wr_en = 1'b0;
    check("skid_snp_out_d1", bus.input_data_1, 32'h1);
    bus.out_ready = 1'b1;
    tick();
    check("skid_snp_d1", bus.input_data_1, 32'h77);
    tick();
    check("skid_snp_drain", bus.out_valid, 0);

    // flush with both entries full and a new input offered
    bus.out_ready = 1'b0;
    send(32'hC1, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'h0, 32'h600);
    tick();
    send(32'hC2, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'h0, 32'h604);
    tick();
    check("fl_full", bus.in_ready, 0);
    send(32'hC3, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'h0, 32'h608);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_valid", bus.out_valid, 0);
    check("fl_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_late", bus.out_valid, 0);
    end
    send(32'hD1, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd3, 4'h0, 32'h700);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_empty_in", bus.out_valid, 0);

    // asynchronous reset while an entry is presented
    bus.out_ready = 1'b0;
    send(32'h5A, 32'h6B, 32'h0, 1'b0, 5'd1, 5'd2, 5'd8, 4'h7, 32'h800);
    tick();
    idle();
    check("ar_pre_valid", bus.out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_in_ready", bus.in_ready, 1);
    check("ar_d1", bus.input_data_1, 0);
    check("ar_d2", bus.input_data_2, 0);
    check("ar_ctl", bus.ALU_control, 0);
    check("ar_pc", bus.pc, 0);
    check("ar_rd", bus.out_rd_addr, 0);
    #2 rst_n = 1'b1;
    send(32'h42, 32'h43, 32'h0, 1'b0, 5'd1, 5'd2, 5'd9, 4'h2, 32'h900);
    bus.out_ready = 1'b1;
    tick();
    idle();
    check("ar_first_valid", bus.out_valid, 1);
    check("ar_first_d1", bus.input_data_1, 32'h42);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_issue.md
ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 SHALL have parameter ALU_DATA_WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter ALU_CONTROL_WIDTH, default 4, ALU operation code width.
REQ-003 SHALL have parameter INST_ADDR_WIDTH, default 32, instruction address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the decode-side handshake.
REQ-007 SHALL have ports in_rs1_data, in_rs2_data, in_imm  input  ALU_DATA_WIDTH  register-file values and immediate.
REQ-008 SHALL have ports in_rs1_addr, in_rs2_addr, in_rd_addr  input  5  source and destination register numbers.
REQ-009 SHALL have ports in_use_imm input 1 (operand 2 is the immediate) and in_alu_control input ALU_CONTROL_WIDTH.
REQ-010 SHALL have port in_pc  input  INST_ADDR_WIDTH  instruction address.
REQ-011 SHALL have ports exm_wr_en input 1, exm_rd input 5, exm_data input ALU_DATA_WIDTH: EX/MEM forwarding source.
REQ-012 SHALL have ports mwb_wr_en input 1, mwb_rd input 5, mwb_data input ALU_DATA_WIDTH: MEM/WB writeback source.
REQ-013 SHALL have port flush  input  1  discard all held and incoming instructions.
REQ-014 SHALL have ports out_valid output 1 and out_ready input 1, the ALU-side handshake.
REQ-015 SHALL have ports input_data_1, input_data_2  output  ALU_DATA_WIDTH; ALU_control output ALU_CONTROL_WIDTH; pc output INST_ADDR_WIDTH; out_rd_addr output 5; all driving the ALU directly.

Function
REQ-016 SHALL hold two entries, OUT (drives outputs) and SKID, each with valid, rs1 value, rs2 value, imm, use_imm, rs1/rs2/rd addresses, alu_control, pc.
REQ-017 SHALL drive in_ready = NOT skid_valid, combinationally from registered state only.
REQ-018 Input accepted when in_valid AND in_ready; output consumed when out_valid AND out_ready.
REQ-019 Accepted input SHALL load OUT if OUT is empty or consumed that cycle and SKID is empty; otherwise it SHALL load SKID.
REQ-020 When OUT is consumed and SKID is valid, SKID SHALL move to OUT and SKID becomes empty.
REQ-021 Latency SHALL be one cycle: input accepted in cycle N appears on outputs in cycle N+1 when the path is clear.
REQ-022 out_valid and all data outputs SHALL remain stable while out_valid=1 and out_ready=0, except snoop updates per REQ-025.
REQ-023 At capture, each source value SHALL be selected: EX/MEM if exm_wr_en and exm_rd equals the source address; else MEM/WB if mwb_wr_en and address match; else the in_ data.
REQ-024 Register number 0 SHALL never be forwarded or snooped; its value is taken from in_ data unchanged.
REQ-025 Each cycle, every valid held entry SHALL replace a stored rs1/rs2 value with mwb_data when mwb_wr_en and mwb_rd matches that nonzero source address.
REQ-026 input_data_1 SHALL be OUT rs1 value; input_data_2 SHALL be OUT imm if use_imm else OUT rs2 value.
REQ-027 flush SHALL clear OUT and SKID valid at the next edge; an input presented in the flush cycle SHALL be discarded; flush has priority over every transfer.
REQ-028 Data fields of invalid entries are don't-care, but out_valid SHALL never assert for a discarded instruction.
REQ-029 No ordering inversion: instructions SHALL leave in acceptance order.

Reset
REQ-030 While rst_n=0: OUT and SKID valid = 0, all data fields = 0, out_valid=0, in_ready=1, all data outputs = 0.
REQ-031 Reset assertion mid-transfer SHALL drop both entries immediately, without waiting for clk.
REQ-032 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset, then in_valid=1 with rs1_data=5, rs2_data=7, use_imm=0, out_ready=1 -> next cycle out_valid=1, input_data_1=5, input_data_2=7.
REQ-034 out_ready=0, two back-to-back inputs A then B -> in_ready=0 after B; raise out_ready -> A then B out in consecutive cycles, in_ready=1 after A leaves.
REQ-035 in_rs1_addr=3, exm_wr_en=1 exm_rd=3 exm_data=0x11, mwb_wr_en=1 mwb_rd=3 mwb_data=0x22 -> input_data_1=0x11; same with rs1_addr=0 -> in_rs1_data passed.
REQ-036 Entry held with out_ready=0, rs2_addr=9; mwb_wr_en=1 mwb_rd=9 mwb_data=0xAB -> next cycle input_data_2=0xAB (use_imm=0); with use_imm=1 and imm=0x40 -> input_data_2=0x40.
REQ-037 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no later output of any of the three.
REQ-038 rst_n pulsed low asynchronously while out_valid=1 -> out_valid=0 before next clk edge; all outputs 0.
